gcd_arb: RTL

GCD_ARB -- requirements
Module: gcd_arb

---
 rtl/gcd_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gcd_arb.sv
// gcd_arb: round-robin arbiter sharing one GCD engine between two requesters.
// Latency: gnt one cycle after the request is sampled; zero-operand bypass done one cycle later;
//   engine path done two cycles after the engine's eng_done pulse; timeout after TIMEOUT WAIT cycles.
// Backpressure: one job in flight; other requests stay pending (reqN held) until the FSM returns to IDLE.
//
// Ports:
//   clk, clr               clock, synchronous active-high reset (also resets the shared engine)
//   req0/1, x0/y0, x1/y1   per-requester job request and operands (stable while reqN=1)
//   gnt0/1                 one-cycle pulse: operands captured
//   done0/1, res0/1, err0/1  one-cycle done pulse; result/timeout flag held until the next done on that port
//   busy                   FSM not IDLE
//   eng_go, eng_x, eng_y   start pulse and operands to the engine
//   eng_done, eng_gcd      engine completion pulse and result
module gcd_arb #(
    parameter int W       = 4,
    parameter int TIMEOUT = 63
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] res0,
    output logic [W-1:0] res1,
    output logic         err0,
    output logic         err1,
    output logic         busy,
    output logic         eng_go,
    output logic [W-1:0] eng_x,
    output logic [W-1:0] eng_y,
    input  logic         eng_done,
    input  logic [W-1:0] eng_gcd
);

    // Counter only has to reach TIMEOUT-1: WAIT lasts exactly TIMEOUT cycles.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t         state;
    state_t         nxt;

    logic           owner;    // port of the job in flight
    logic           last;     // port served most recently
    logic [W-1:0]   xl;
    logic [W-1:0]   yl;
    logic [W-1:0]   rl;       // pending result, copied to the owner's port in RESP
    logic           el;       // pending timeout flag
    logic [CW-1:0]  cnt;

    logic           any_req;
    logic           win;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;
    logic           timeout;

    // Arbitration: a tie goes to the port that was not served last.
    always_comb begin
        any_req = req0 | req1;
        win     = (req0 && req1) ? ~last : req1;
        sel_x   = win ? x1 : x0;
        sel_y   = win ? y1 : y0;
        timeout = (cnt == CW'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    nxt = (sel_x == '0 || sel_y == '0) ? RESP : LAUNCH;
                end
            end
            LAUNCH: nxt = WAIT;
            WAIT: begin
                if (eng_done || timeout) begin
                    nxt = RESP;
                end
            end
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Engine-facing outputs; operands are gated so the engine sees zeros outside a job.
    always_comb begin
        eng_go = (state == LAUNCH);
        eng_x  = '0;
        eng_y  = '0;
        if (state == LAUNCH || state == WAIT) begin
            eng_x = xl;
            eng_y = yl;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            owner <= 1'b0;
            last  <= 1'b1;
            xl    <= '0;
            yl    <= '0;
            rl    <= '0;
            el    <= 1'b0;
            cnt   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            res0  <= '0;
            res1  <= '0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= (nxt != IDLE);
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= win;
                        xl    <= sel_x;
                        yl    <= sel_y;
                        // gcd(a,0)=a and gcd(0,0)=0, so OR of the operands is the bypass result.
                        rl    <= sel_x | sel_y;
                        el    <= 1'b0;
                        gnt0  <= ~win;
                        gnt1  <= win;
                    end
                end
                LAUNCH: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (eng_done) begin
                        rl <= eng_gcd;
                        el <= 1'b0;
                    end else if (timeout) begin
                        rl <= '0;
                        el <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    last <= owner;
                    if (owner) begin
                        done1 <= 1'b1;
                        res1  <= rl;
                        err1  <= el;
                    end else begin
                        done0 <= 1'b1;
                        res0  <= rl;
                        err0  <= el;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
